program_operation: RTL and testbench

- NAND-flash page-program controller; write-direction counterpart of the read_operation controller.
- Accepts a start request with a 16-bit address and byte count, issues the 0x80 / address / data / 0x10 sequence on the 8-bit flash bus, and waits on R/B.
- Reads back the status register and reports completion, pass/fail and timeout to the host.

---
 rtl/program_operation.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_program_operation.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_operation.sv
// ---------------------------------------------------------------------------
// program_operation
//
// NAND-flash page-program controller. This is the write-direction counterpart
// of read_operation. A host start request (address + byte count) makes the
// controller issue the sequence
//     0x80 (CLE) / addr low (ALE) / addr high (ALE) / data bytes / 0x10 (CLE)
// on the 8-bit flash bus. It then waits tWB and polls R/B. Once the array is
// ready again it reads the status register (0x70 + one RE read) and reports
// the outcome.
//
// Ports
//   clk, reset          system clock (rising edge), synchronous active-high reset
//   start, addr, len    host request; accepted only while is_ready_out=1
//   wr_data, wr_valid,  host data stream, one byte per wr_valid&wr_ready
//   wr_ready
//   CE, CLE, ALE, WE,   flash control strobes (CE/WE/RE active-low)
//   RE
//   RB                  flash ready/busy (0 = busy)
//   io_in, io_out,      flash data bus; io_oe enables the output side
//   io_oe
//   complete            one-cycle pulse when an operation ends
//   is_ready_out        controller idle
//   status, fail,       last status byte, pass/fail, busy timeout
//   timeout
//   bytes_written       data bytes sent in the current/last operation
// ---------------------------------------------------------------------------
module program_operation #(
    parameter logic [7:0]  CMD_PROG1    = 8'h80,
    parameter logic [7:0]  CMD_PROG2    = 8'h10,
    parameter logic [7:0]  CMD_STATUS   = 8'h70,
    parameter int unsigned TWB_CYC      = 4,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        CE,
    output logic        CLE,
    output logic        ALE,
    output logic        WE,
    output logic        RE,
    input  logic        RB,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic        io_oe,
    output logic        complete,
    output logic        is_ready_out,
    output logic [7:0]  status,
    output logic        fail,
    output logic        timeout,
    output logic [7:0]  bytes_written
);

    typedef enum logic [3:0] {
        IDLE,
        CMD1,
        ADDR0,
        ADDR1,
        DATA,
        CMD2,
        TWB,
        WAIT_RB,
        STAT_CMD,
        STAT_RD,
        DONE
    } state_t;

    // Sub-cycle position inside a state.
    //   Bus write states: PH0 = WE low, PH1 = WE high (data held).
    //   DATA additionally uses PH2 = no byte on the bus (stall / waiting).
    //   STAT_RD: PH0/PH1 = RE low (capture in PH1), PH2 = RE high.
    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2
    } phase_t;

    state_t      state;
    state_t      next_state;
    phase_t      sub;
    phase_t      next_sub;

    logic [15:0] addr_reg;
    logic [7:0]  len_reg;
    logic [7:0]  data_reg;
    logic [7:0]  twb_cnt;
    logic [15:0] busy_cnt;

    logic        accept;
    logic        twb_done;
    logic        busy_expired;

    assign accept       = wr_valid & wr_ready;
    assign twb_done     = (twb_cnt == 8'(TWB_CYC - 1));
    assign busy_expired = (busy_cnt == (BUSY_TIMEOUT - 16'd1));

    // State register: the FSM position and its sub-cycle phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sub   <= PH0;
        end else begin
            state <= next_state;
            sub   <= next_sub;
        end
    end

    // Next-state logic. Every bus write cycle takes PH0 then PH1. DATA leaves
    // through CMD2 once the last byte has reached its WE-high phase, so the
    // flash has latched it before the confirm command starts.
    always_comb begin
        next_state = state;
        next_sub   = sub;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CMD1;
                    next_sub   = PH0;
                end
            end
            CMD1: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else begin
                    next_state = ADDR0;
                    next_sub   = PH0;
                end
            end
            ADDR0: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else begin
                    next_state = ADDR1;
                    next_sub   = PH0;
                end
            end
            ADDR1: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else if (len_reg == 8'd0) begin
                    next_state = CMD2;
                    next_sub   = PH0;
                end else begin
                    next_state = DATA;
                    next_sub   = PH2;
                end
            end
            DATA: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else if (bytes_written == len_reg) begin
                    next_state = CMD2;
                    next_sub   = PH0;
                end else if (accept) begin
                    next_sub = PH0;
                end else begin
                    next_sub = PH2;
                end
            end
            CMD2: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else begin
                    next_state = TWB;
                    next_sub   = PH0;
                end
            end
            TWB: begin
                if (twb_done) begin
                    next_state = WAIT_RB;
                end
            end
            WAIT_RB: begin
                if (RB) begin
                    next_state = STAT_CMD;
                    next_sub   = PH0;
                end else if (busy_expired) begin
                    next_state = DONE;
                end
            end
            STAT_CMD: begin
                if (sub == PH0) begin
                    next_sub = PH1;
                end else begin
                    next_state = STAT_RD;
                    next_sub   = PH0;
                end
            end
            STAT_RD: begin
                case (sub)
                    PH0:     next_sub = PH1;
                    PH1:     next_sub = PH2;
                    default: begin
                        next_state = DONE;
                        next_sub   = PH0;
                    end
                endcase
            end
            DONE: begin
                next_state = IDLE;
                next_sub   = PH0;
            end
            default: begin
                next_state = IDLE;
                next_sub   = PH0;
            end
        endcase
    end

    // Datapath registers. These are the request latch, the data holding
    // register, the tWB and busy counters, and the host-visible result
    // registers. status and fail keep their values between operations.
    // status is only overwritten by a completed status read.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= 16'h0000;
            len_reg       <= 8'h00;
            data_reg      <= 8'h00;
            twb_cnt       <= 8'h00;
            busy_cnt      <= 16'h0000;
            status        <= 8'h00;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            bytes_written <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_reg      <= addr;
                        len_reg       <= len;
                        bytes_written <= 8'h00;
                        fail          <= 1'b0;
                        timeout       <= 1'b0;
                    end
                end
                DATA: begin
                    if (sub == PH0) begin
                        bytes_written <= bytes_written + 8'd1;
                    end else if (accept) begin
                        data_reg <= wr_data;
                    end
                end
                CMD2: begin
                    twb_cnt <= 8'h00;
                end
                TWB: begin
                    twb_cnt  <= twb_cnt + 8'd1;
                    busy_cnt <= 16'h0000;
                end
                WAIT_RB: begin
                    if (!RB) begin
                        busy_cnt <= busy_cnt + 16'd1;
                        if (busy_expired) begin
                            timeout <= 1'b1;
                            fail    <= 1'b1;
                        end
                    end
                end
                STAT_RD: begin
                    if (sub == PH1) begin
                        status <= io_in;
                        fail   <= io_in[0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from state and phase only, so the strobes are clean.
    // io_oe is only raised in write states, and RE only falls in STAT_RD.
    // This keeps the bus from being driven while the flash drives it.
    always_comb begin
        CE           = 1'b0;
        WE           = 1'b1;
        RE           = 1'b1;
        CLE          = 1'b0;
        ALE          = 1'b0;
        io_oe        = 1'b0;
        io_out       = 8'h00;
        wr_ready     = 1'b0;
        complete     = 1'b0;
        is_ready_out = 1'b0;
        case (state)
            IDLE: begin
                CE           = 1'b1;
                is_ready_out = 1'b1;
            end
            CMD1: begin
                CLE    = 1'b1;
                io_oe  = 1'b1;
                io_out = CMD_PROG1;
                WE     = (sub != PH0);
            end
            ADDR0: begin
                ALE    = 1'b1;
                io_oe  = 1'b1;
                io_out = addr_reg[7:0];
                WE     = (sub != PH0);
            end
            ADDR1: begin
                ALE    = 1'b1;
                io_oe  = 1'b1;
                io_out = addr_reg[15:8];
                WE     = (sub != PH0);
            end
            DATA: begin
                if (sub != PH2) begin
                    io_oe  = 1'b1;
                    io_out = data_reg;
                    WE     = (sub != PH0);
                end
                wr_ready = (sub != PH0) && (bytes_written != len_reg);
            end
            CMD2: begin
                CLE    = 1'b1;
                io_oe  = 1'b1;
                io_out = CMD_PROG2;
                WE     = (sub != PH0);
            end
            STAT_CMD: begin
                CLE    = 1'b1;
                io_oe  = 1'b1;
                io_out = CMD_STATUS;
                WE     = (sub != PH0);
            end
            STAT_RD: begin
                RE = (sub == PH2);
            end
            DONE: begin
                CE       = 1'b1;
                complete = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_program_operation.sv
// ---------------------------------------------------------------------------
// tb_program_operation
//
// Randomized self-checking bench for program_operation. A single agent process
// plays both the host data source and the flash device:
//   - it watches WE rising edges and records every latched bus byte;
//   - it pulls RB low after a 0x10 confirm for a chosen number of cycles;
//   - it feeds data bytes with configurable gaps.
// Expected bus traffic and results come from the command-sequence rules of the
// controller, not from its state machine.
// ---------------------------------------------------------------------------
module tb_program_operation;

    localparam int BUSY_TIMEOUT = 50000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        CE, CLE, ALE, WE, RE;
    logic        RB;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic        io_oe;
    logic        complete;
    logic        is_ready_out;
    logic [7:0]  status;
    logic        fail;
    logic        timeout;
    logic [7:0]  bytes_written;

    program_operation dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .addr          (addr),
        .len           (len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .CE            (CE),
        .CLE           (CLE),
        .ALE           (ALE),
        .WE            (WE),
        .RE            (RE),
        .RB            (RB),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_oe         (io_oe),
        .complete      (complete),
        .is_ready_out  (is_ready_out),
        .status        (status),
        .fail          (fail),
        .timeout       (timeout),
        .bytes_written (bytes_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecCount  = 0;
    int missCount = 0;

    // Agent state, shared between the main sequence and the agent process.
    logic [7:0] dataQ[$];
    logic [9:0] busQ[$];
    int  gapCycles  = 0;
    int  busyCycles = 0;
    bit  opReset    = 1'b0;
    int  dIdx, gapLeft, busyRemain;
    bit  pend;
    int  completeCnt, reLowCnt, hsCnt, wrReadyCnt;
    int  protoErr = 0;
    int  weErr    = 0;
    bit  weLowPrev;
    int  lowLen;
    logic [7:0] capByte;
    logic       capCle, capAle;
    logic [7:0] lastStatus;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Flash model, host data source and bus monitor, all sampled on the
    // falling edge where DUT outputs are stable.
    initial begin
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        RB         = 1'b1;
        dIdx       = 0;
        gapLeft    = 0;
        busyRemain = 0;
        pend       = 1'b0;
        weLowPrev  = 1'b0;
        lowLen     = 0;
        completeCnt = 0; reLowCnt = 0; hsCnt = 0; wrReadyCnt = 0;
        forever begin
            @(negedge clk);
            if (opReset) begin
                dIdx = 0; gapLeft = 0; pend = 1'b0; busyRemain = 0; RB = 1'b1;
                busQ.delete();
                completeCnt = 0; reLowCnt = 0; hsCnt = 0; wrReadyCnt = 0;
                weLowPrev = 1'b0;
                opReset = 1'b0;
            end
            if (busyRemain > 0) begin
                busyRemain--;
                if (busyRemain == 0) RB = 1'b1;
            end
            if (io_oe && !RE) protoErr++;
            if (CLE && ALE) protoErr++;
            if (!RE) reLowCnt++;
            if (complete) completeCnt++;
            if (wr_ready) wrReadyCnt++;
            if (reset) begin
                weLowPrev = 1'b0;
            end else if (WE == 1'b0) begin
                if (!weLowPrev) begin
                    capByte = io_out; capCle = CLE; capAle = ALE; lowLen = 0;
                    if (!io_oe || CE) weErr++;
                end
                lowLen++;
                weLowPrev = 1'b1;
            end else if (weLowPrev) begin
                weLowPrev = 1'b0;
                if (lowLen != 1) weErr++;
                if (!io_oe || io_out != capByte || CLE != capCle || ALE != capAle) weErr++;
                busQ.push_back({capCle, capAle, capByte});
                if (capCle && capByte == 8'h10) begin
                    RB = 1'b0;
                    busyRemain = busyCycles;
                end
            end
            if (pend) begin
                dIdx++;
                hsCnt++;
                gapLeft = gapCycles;
            end
            if (gapLeft > 0) begin
                wr_valid = 1'b0;
                gapLeft--;
            end else if (dIdx < dataQ.size()) begin
                wr_valid = 1'b1;
                wr_data  = dataQ[dIdx];
            end else begin
                wr_valid = 1'b0;
            end
            pend = wr_valid && wr_ready && !reset;
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ctl"},
                    32'({CE, WE, RE, CLE, ALE, io_oe, wr_ready, complete,
                         is_ready_out, timeout, fail}),
                    32'(11'b111_000_00_1_00));
        checkOutput({tag, "_data"}, 32'({io_out, status, bytes_written}), 32'h0);
    endtask

    // Prepare the agent for a new operation: data bytes, gap, busy time.
    task automatic prepareOp(input logic [7:0] l, input int gapC, input int busyC,
                             input logic [7:0] st, input bit fixedData);
        dataQ.delete();
        for (int i = 0; i < int'(l); i++) begin
            if (fixedData) dataQ.push_back(8'h55 + 8'(2 * i));
            else           dataQ.push_back(8'($urandom));
        end
        gapCycles  = gapC;
        busyCycles = busyC;
        io_in      = st;
        opReset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One full program operation plus all its result checks.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] l,
                                 input int gapC, input int busyC,
                                 input logic [7:0] st, input bit fixedData,
                                 input bit poke);
        logic [9:0] expQ[$];
        bit         expTmo;
        logic [7:0] expStatus;
        logic       expFail;
        int         waitCnt;
        int         rbSeen;

        prepareOp(l, gapC, busyC, st, fixedData);
        expTmo    = (busyC > BUSY_TIMEOUT);
        expStatus = expTmo ? lastStatus : st;
        expFail   = expTmo ? 1'b1 : st[0];
        expQ.push_back({2'b10, 8'h80});
        expQ.push_back({2'b01, a[7:0]});
        expQ.push_back({2'b01, a[15:8]});
        foreach (dataQ[i]) expQ.push_back({2'b00, dataQ[i]});
        expQ.push_back({2'b10, 8'h10});
        if (!expTmo) expQ.push_back({2'b10, 8'h70});

        start = 1'b1; addr = a; len = l;
        @(negedge clk);
        start = 1'b0; addr = 16'($urandom); len = 8'($urandom);
        checkOutput("ready_drop", 32'(is_ready_out), 32'd0);
        checkOutput("ce_low", 32'(CE), 32'd0);

        waitCnt = 0;
        rbSeen  = 0;
        while (complete !== 1'b1 && waitCnt < 60000) begin
            start = (poke && rbSeen == 8);
            if (RB == 1'b0) rbSeen++;
            @(negedge clk);
            waitCnt++;
        end
        start = 1'b0;
        checkOutput("complete_seen", 32'(complete), 32'd1);
        checkOutput("bytes_written", 32'(bytes_written), 32'(l));
        checkOutput("status", 32'(status), 32'(expStatus));
        checkOutput("fail", 32'(fail), 32'(expFail));
        checkOutput("timeout", 32'(timeout), 32'(expTmo));
        checkOutput("ce_done", 32'(CE), 32'd1);
        if (expTmo)
            checkOutput("tmo_window", 32'(waitCnt >= BUSY_TIMEOUT && waitCnt <= BUSY_TIMEOUT + 30), 32'd1);
        lastStatus = expStatus;

        // A start in the complete cycle must not launch a new operation.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ready_after", 32'(is_ready_out), 32'd1);
        checkOutput("complete_once", 32'(complete), 32'd0);

        checkOutput("bus_len", 32'(busQ.size()), 32'(expQ.size()));
        foreach (expQ[i]) begin
            if (i < busQ.size())
                checkOutput($sformatf("bus%0d", i), 32'(busQ[i]), 32'(expQ[i]));
        end
        checkOutput("complete_cnt", 32'(completeCnt), 32'd1);
        checkOutput("re_low_cnt", 32'(reLowCnt), expTmo ? 32'd0 : 32'd2);
        checkOutput("handshakes", 32'(hsCnt), 32'(l));
        if (l == 8'd0) checkOutput("wr_ready_len0", 32'(wrReadyCnt), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr = 16'h0; len = 8'h0; io_in = 8'h0;
        lastStatus = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(16'h000F, 8'd2, 0, 20, 8'hE0, 1'b1, 1'b0);
        applyStimulus(16'h1234, 8'd3, 5, 15, 8'hC0, 1'b0, 1'b0);
        applyStimulus(16'hABCD, 8'd0, 0, 10, 8'hE0, 1'b0, 1'b0);
        applyStimulus(16'h0102, 8'd1, 0, 20, 8'hE1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            applyStimulus(16'($urandom), 8'($urandom_range(0, 6)),
                          int'($urandom_range(0, 3)), int'($urandom_range(1, 30)),
                          8'($urandom), 1'b0, 1'b0);
        applyStimulus(16'h5555, 8'd0, 0, 60000, 8'hE0, 1'b0, 1'b0);

        // Reset while stalled in the data phase.
        prepareOp(8'd4, 10, 20, 8'hE0, 1'b0);
        start = 1'b1; addr = 16'h4321; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("bw_before_rst", 32'(bytes_written), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("mid_data_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("no_complete_rst", 32'(completeCnt), 32'd0);
        checkOutput("idle_after_rst", 32'(is_ready_out), 32'd1);
        lastStatus = 8'h00;

        applyStimulus(16'h00FF, 8'd2, 1, 12, 8'h60, 1'b0, 1'b0);

        checkOutput("proto_err", 32'(protoErr), 32'd0);
        checkOutput("we_err", 32'(weErr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
